// File: rtl/lsu_ctrl.sv
// Load/store unit bus master: one operation at a time, word-addressed
// request/grant/rvalid bus, misaligned accesses split into two beats,
// load data merged and extended into a one-cycle writeback result.
// lsu_op_ex encoding: 0 = load (LSU_OP_LD), 1 = store (LSU_OP_WR).
module lsu_ctrl #(
    parameter int unsigned SPLIT_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req_ex,
    output logic        lsu_ready_ex,
    input  logic        lsu_op_ex,
    input  logic [1:0]  lsu_size_ex,
    input  logic        lsu_sext_ex,
    input  logic [31:0] lsu_addr_ex,
    input  logic [31:0] lsu_wdata_ex,
    input  logic        flush,
    output logic        data_req,
    input  logic        data_gnt,
    output logic        data_we,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_rvalid,
    input  logic [31:0] data_rdata,
    input  logic        data_err,
    output logic        lsu_valid_wb,
    output logic [31:0] lsu_rdata_wb,
    output logic        lsu_err_wb
);

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_e;

    state_e      state_q, state_d;
    logic        op_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf1_q;
    logic [31:0] buf2_q;
    logic        split_q;
    logic        err_q;
    logic        killed_q;

    logic        accept;
    logic        misal_ex;
    logic        split_ex;
    logic        illegal_ex;
    logic [3:0]  mask_q;
    logic [7:0]  be8_q;
    logic [63:0] wide_q;
    logic [31:0] raw;
    logic [31:0] ext;

    assign lsu_ready_ex = (state_q == IDLE);
    assign accept       = lsu_req_ex & lsu_ready_ex & ~flush;

    // Misalignment means the shifted byte mask would spill past byte lane 3
    assign misal_ex   = ((lsu_size_ex == 2'b01) && (lsu_addr_ex[1:0] == 2'b11)) ||
                        ((lsu_size_ex == 2'b10) && (lsu_addr_ex[1:0] != 2'b00));
    assign split_ex   = (SPLIT_MISALIGNED != 0) && misal_ex;
    assign illegal_ex = (lsu_size_ex == 2'b11) || (misal_ex && (SPLIT_MISALIGNED == 0));

    // Lane-aligned enables and store data for both beats; upper halves feed beat 2
    always_comb begin
        case (size_q)
            2'b00:   mask_q = 4'b0001;
            2'b01:   mask_q = 4'b0011;
            default: mask_q = 4'b1111;
        endcase
        be8_q  = {4'b0000, mask_q} << addr_q[1:0];
        wide_q = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    end

    // Load merge: realign the two beats, then extend by size
    always_comb begin
        raw = 32'({buf2_q, buf1_q} >> {addr_q[1:0], 3'b000});
        case (size_q)
            2'b00:   ext = sext_q ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            2'b01:   ext = sext_q ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

    assign lsu_valid_wb = (state_q == RESP);
    assign lsu_err_wb   = (state_q == RESP) & err_q;
    assign lsu_rdata_wb = ((state_q == RESP) && !err_q && !op_q) ? ext : '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and bus request outputs
    always_comb begin
        state_d    = state_q;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = '0;
        data_addr  = '0;
        data_wdata = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = illegal_ex ? RESP : REQ1;
            end
            REQ1: begin
                data_req   = 1'b1;
                data_we    = op_q;
                data_be    = be8_q[3:0];
                data_addr  = {addr_q[31:2], 2'b00};
                data_wdata = wide_q[31:0];
                if (data_gnt)   state_d = WAIT1;
                else if (flush) state_d = IDLE;
            end
            WAIT1: begin
                if (data_rvalid) begin
                    if (killed_q || flush)        state_d = IDLE;
                    else if (data_err || !split_q) state_d = RESP;
                    else                          state_d = REQ2;
                end
            end
            REQ2: begin
                data_req   = 1'b1;
                data_we    = op_q;
                data_be    = be8_q[7:4];
                data_addr  = {addr_q[31:2] + 30'd1, 2'b00};
                data_wdata = wide_q[63:32];
                if (data_gnt)   state_d = WAIT2;
                else if (flush) state_d = IDLE;
            end
            WAIT2: begin
                if (data_rvalid) state_d = (killed_q || flush) ? IDLE : RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operation registers, response buffers, error and kill tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= 1'b0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf1_q   <= '0;
            buf2_q   <= '0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= lsu_op_ex;
                size_q   <= lsu_size_ex;
                sext_q   <= lsu_sext_ex;
                addr_q   <= lsu_addr_ex;
                wdata_q  <= lsu_wdata_ex;
                split_q  <= split_ex;
                err_q    <= illegal_ex;
                killed_q <= 1'b0;
            end
            case (state_q)
                // A flush coinciding with a grant still owes us the response
                REQ1, REQ2: if (flush && data_gnt) killed_q <= 1'b1;
                WAIT1: begin
                    if (data_rvalid) begin
                        buf1_q <= data_rdata;
                        err_q  <= data_err;
                    end
                    if (flush) killed_q <= 1'b1;
                end
                WAIT2: begin
                    if (data_rvalid) begin
                        buf2_q <= data_rdata;
                        err_q  <= err_q | data_err;
                    end
                    if (flush) killed_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: aligned/misaligned loads and
// stores, extension, bus errors, flush, reset, and the no-split variant.
module tb_lsu_ctrl;

    logic        clk;
    logic        reset;
    logic        lsu_req_ex;
    logic        lsu_ready_ex;
    logic        lsu_op_ex;
    logic [1:0]  lsu_size_ex;
    logic        lsu_sext_ex;
    logic [31:0] lsu_addr_ex;
    logic [31:0] lsu_wdata_ex;
    logic        flush;
    logic        data_req;
    logic        data_gnt;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        lsu_valid_wb;
    logic [31:0] lsu_rdata_wb;
    logic        lsu_err_wb;

    logic        ns_req_ex;
    logic        ns_ready_ex;
    logic        ns_data_req;
    logic        ns_data_we;
    logic [3:0]  ns_data_be;
    logic [31:0] ns_data_addr;
    logic [31:0] ns_data_wdata;
    logic        ns_valid_wb;
    logic [31:0] ns_rdata_wb;
    logic        ns_err_wb;

    int n_tests;
    int n_fail;

    localparam logic OP_LD = 1'b0;
    localparam logic OP_WR = 1'b1;

    lsu_ctrl #(.SPLIT_MISALIGNED(1)) u_dut (
        .clk(clk), .reset(reset),
        .lsu_req_ex(lsu_req_ex), .lsu_ready_ex(lsu_ready_ex),
        .lsu_op_ex(lsu_op_ex), .lsu_size_ex(lsu_size_ex), .lsu_sext_ex(lsu_sext_ex),
        .lsu_addr_ex(lsu_addr_ex), .lsu_wdata_ex(lsu_wdata_ex), .flush(flush),
        .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .data_err(data_err),
        .lsu_valid_wb(lsu_valid_wb), .lsu_rdata_wb(lsu_rdata_wb), .lsu_err_wb(lsu_err_wb)
    );

    lsu_ctrl #(.SPLIT_MISALIGNED(0)) u_dut_ns (
        .clk(clk), .reset(reset),
        .lsu_req_ex(ns_req_ex), .lsu_ready_ex(ns_ready_ex),
        .lsu_op_ex(lsu_op_ex), .lsu_size_ex(lsu_size_ex), .lsu_sext_ex(lsu_sext_ex),
        .lsu_addr_ex(lsu_addr_ex), .lsu_wdata_ex(lsu_wdata_ex), .flush(flush),
        .data_req(ns_data_req), .data_gnt(data_gnt), .data_we(ns_data_we), .data_be(ns_data_be),
        .data_addr(ns_data_addr), .data_wdata(ns_data_wdata), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .data_err(data_err),
        .lsu_valid_wb(ns_valid_wb), .lsu_rdata_wb(ns_rdata_wb), .lsu_err_wb(ns_err_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present one request for a single cycle; returns in the first REQ1 cycle
    task automatic issue(input string tag, input logic op, input logic [1:0] size,
                         input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
        lsu_req_ex   = 1'b1;
        lsu_op_ex    = op;
        lsu_size_ex  = size;
        lsu_sext_ex  = sext;
        lsu_addr_ex  = addr;
        lsu_wdata_ex = wdata;
        check({tag, ".ready"}, 32'(lsu_ready_ex), 32'd1);
        step();
        lsu_req_ex = 1'b0;
    endtask

    // Check a request cycle, grant at once, respond the cycle after
    task automatic beat(input string tag, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic e_we, input logic [31:0] e_wdata,
                        input logic [31:0] rd, input logic er);
        check({tag, ".req"}, 32'(data_req), 32'd1);
        check({tag, ".addr"}, data_addr, e_addr);
        check({tag, ".be"}, 32'(data_be), 32'(e_be));
        check({tag, ".we"}, 32'(data_we), 32'(e_we));
        check({tag, ".wdata"}, data_wdata, e_wdata);
        data_gnt = 1'b1;
        step();
        data_gnt = 1'b0;
        check({tag, ".req_wait"}, 32'(data_req), 32'd0);
        data_rvalid = 1'b1;
        data_rdata  = rd;
        data_err    = er;
        step();
        data_rvalid = 1'b0;
        data_rdata  = '0;
        data_err    = 1'b0;
    endtask

    // Check the one-cycle writeback pulse and the return to idle
    task automatic result(input string tag, input logic [31:0] e_rdata, input logic e_err);
        check({tag, ".valid"}, 32'(lsu_valid_wb), 32'd1);
        check({tag, ".rdata"}, lsu_rdata_wb, e_rdata);
        check({tag, ".err"}, 32'(lsu_err_wb), 32'(e_err));
        step();
        check({tag, ".valid_end"}, 32'(lsu_valid_wb), 32'd0);
        check({tag, ".ready_end"}, 32'(lsu_ready_ex), 32'd1);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        lsu_req_ex   = 1'b0;
        ns_req_ex    = 1'b0;
        lsu_op_ex    = OP_LD;
        lsu_size_ex  = 2'b00;
        lsu_sext_ex  = 1'b0;
        lsu_addr_ex  = '0;
        lsu_wdata_ex = '0;
        flush        = 1'b0;
        data_gnt     = 1'b0;
        data_rvalid  = 1'b0;
        data_rdata   = '0;
        data_err     = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        check("rst.ready", 32'(lsu_ready_ex), 32'd1);
        check("rst.req", 32'(data_req), 32'd0);
        check("rst.addr", data_addr, 32'h0);
        check("rst.be", 32'(data_be), 32'h0);
        check("rst.valid", 32'(lsu_valid_wb), 32'd0);
        check("rst.rdata", lsu_rdata_wb, 32'h0);

        // Aligned LW: valid appears three cycles after accept
        issue("lw", OP_LD, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        beat("lw.b1", 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        result("lw", 32'hDEAD_BEEF, 1'b0);

        // LB sign-extended and LBU at byte 3
        issue("lb", OP_LD, 2'b00, 1'b1, 32'h0000_0203, 32'h0);
        beat("lb.b1", 32'h0000_0200, 4'b1000, 1'b0, 32'h0, 32'h8011_2233, 1'b0);
        result("lb", 32'hFFFF_FF80, 1'b0);
        issue("lbu", OP_LD, 2'b00, 1'b0, 32'h0000_0203, 32'h0);
        beat("lbu.b1", 32'h0000_0200, 4'b1000, 1'b0, 32'h0, 32'h8011_2233, 1'b0);
        result("lbu", 32'h0000_0080, 1'b0);

        // LH sign-extended at offset 2 (aligned half in upper lanes)
        issue("lh", OP_LD, 2'b01, 1'b1, 32'h0000_0602, 32'h0);
        beat("lh.b1", 32'h0000_0600, 4'b1100, 1'b0, 32'h0, 32'h9ABC_1234, 1'b0);
        result("lh", 32'hFFFF_9ABC, 1'b0);

        // Misaligned LW split into two beats
        issue("mlw", OP_LD, 2'b10, 1'b0, 32'h0000_0302, 32'h0);
        beat("mlw.b1", 32'h0000_0300, 4'b1100, 1'b0, 32'h0, 32'hAABB_CCDD, 1'b0);
        beat("mlw.b2", 32'h0000_0304, 4'b0011, 1'b0, 32'h0, 32'h1122_3344, 1'b0);
        result("mlw", 32'h3344_AABB, 1'b0);

        // Misaligned LW across the top of the address space wraps to 0
        issue("wrap", OP_LD, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);
        beat("wrap.b1", 32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0, 32'hAABB_CCDD, 1'b0);
        beat("wrap.b2", 32'h0000_0000, 4'b0011, 1'b0, 32'h0, 32'h1122_3344, 1'b0);
        result("wrap", 32'h3344_AABB, 1'b0);

        // Misaligned SW
        issue("msw", OP_WR, 2'b10, 1'b0, 32'h0000_0401, 32'h1234_5678);
        beat("msw.b1", 32'h0000_0400, 4'b1110, 1'b1, 32'h3456_7800, 32'h0, 1'b0);
        beat("msw.b2", 32'h0000_0404, 4'b0001, 1'b1, 32'h0000_0012, 32'h0, 1'b0);
        result("msw", 32'h0, 1'b0);

        // Misaligned load, first beat errors: no second request
        issue("merr", OP_LD, 2'b10, 1'b0, 32'h0000_0302, 32'h0);
        beat("merr.b1", 32'h0000_0300, 4'b1100, 1'b0, 32'h0, 32'h5555_5555, 1'b1);
        check("merr.no_b2", 32'(data_req), 32'd0);
        result("merr", 32'h0, 1'b1);

        // Illegal size 11 returns error without bus traffic
        issue("ill", OP_LD, 2'b11, 1'b0, 32'h0000_0700, 32'h0);
        check("ill.req", 32'(data_req), 32'd0);
        result("ill", 32'h0, 1'b1);

        // No-split variant: misaligned LH errors the cycle after accept
        ns_req_ex   = 1'b1;
        lsu_op_ex   = OP_LD;
        lsu_size_ex = 2'b01;
        lsu_addr_ex = 32'h0000_0003;
        step();
        ns_req_ex = 1'b0;
        check("ns.valid", 32'(ns_valid_wb), 32'd1);
        check("ns.err", 32'(ns_err_wb), 32'd1);
        check("ns.rdata", ns_rdata_wb, 32'h0);
        check("ns.req", 32'(ns_data_req), 32'd0);
        step();
        check("ns.valid_end", 32'(ns_valid_wb), 32'd0);
        check("ns.req_end", 32'(ns_data_req), 32'd0);

        // Flush in the same cycle as the request blocks the accept
        lsu_req_ex  = 1'b1;
        flush       = 1'b1;
        lsu_size_ex = 2'b10;
        lsu_addr_ex = 32'h0000_0800;
        step();
        lsu_req_ex = 1'b0;
        flush      = 1'b0;
        check("fblk.req", 32'(data_req), 32'd0);
        check("fblk.ready", 32'(lsu_ready_ex), 32'd1);

        // Grant withheld three cycles, then flush in REQ1
        issue("gw", OP_LD, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("gw.req", 32'(data_req), 32'd1);
            check("gw.addr", data_addr, 32'h0000_0500);
            check("gw.be", 32'(data_be), 32'hF);
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("gw.req_drop", 32'(data_req), 32'd0);
        check("gw.ready", 32'(lsu_ready_ex), 32'd1);
        check("gw.valid", 32'(lsu_valid_wb), 32'd0);
        step();
        check("gw.valid2", 32'(lsu_valid_wb), 32'd0);

        // Flush in WAIT1 of a split load: response consumed, no beat 2, no result
        issue("fw", OP_LD, 2'b10, 1'b0, 32'h0000_0302, 32'h0);
        data_gnt = 1'b1;
        step();
        data_gnt = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check("fw.req_wait", 32'(data_req), 32'd0);
        check("fw.busy", 32'(lsu_ready_ex), 32'd0);
        data_rvalid = 1'b1;
        data_rdata  = 32'h1234_5678;
        step();
        data_rvalid = 1'b0;
        check("fw.no_b2", 32'(data_req), 32'd0);
        check("fw.valid", 32'(lsu_valid_wb), 32'd0);
        check("fw.ready", 32'(lsu_ready_ex), 32'd1);

        // Reset in WAIT1, then a late response arrives in IDLE
        issue("rw", OP_LD, 2'b10, 1'b0, 32'h0000_0900, 32'h0);
        data_gnt = 1'b1;
        step();
        data_gnt = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        check("rw.ready", 32'(lsu_ready_ex), 32'd1);
        check("rw.req", 32'(data_req), 32'd0);
        data_rvalid = 1'b1;
        data_rdata  = 32'hCAFE_F00D;
        step();
        data_rvalid = 1'b0;
        check("rw.valid", 32'(lsu_valid_wb), 32'd0);
        check("rw.ready2", 32'(lsu_ready_ex), 32'd1);
        step();
        check("rw.valid2", 32'(lsu_valid_wb), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit bus master. Accepts one memory operation at a time from the execute stage and drives a word-addressed data-bus request/grant/rvalid handshake.
- Splits misaligned accesses into two bus beats, merges and extends load data, and returns a one-cycle result to the writeback stage on lsu_valid_wb, lsu_rdata_wb and lsu_err_wb.
- It is the producing end of the LSU response interface that writeback consumes.

Parameters:
- SPLIT_MISALIGNED, 1: when 1, misaligned half/word accesses issue two beats. When 0, they return lsu_err_wb without any bus access.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- lsu_req_ex  in  1  operation request from execute
- lsu_ready_ex  out  1  high only in IDLE; accept = lsu_req_ex & lsu_ready_ex & ~flush
- lsu_op_ex  in  lsu_op_e  LSU_OP_LD or LSU_OP_WR
- lsu_size_ex  in  2  00 byte, 01 half, 10 word, 11 illegal
- lsu_sext_ex  in  1  sign-extend load result
- lsu_addr_ex  in  32  byte address
- lsu_wdata_ex  in  32  store data, right-aligned
- flush  in  1  kill the in-flight operation
- data_req  out  1  bus request
- data_gnt  in  1  bus grant
- data_we  out  1  1 = write
- data_be  out  4  byte enables
- data_addr  out  32  word address, bits [1:0] = 0
- data_wdata  out  32  lane-aligned store data
- data_rvalid  in  1  response valid
- data_rdata  in  32  response data
- data_err  in  1  response error, qualified by data_rvalid
- lsu_valid_wb  out  1  one-cycle result pulse
- lsu_rdata_wb  out  32  extended load data; 0 for stores and on error
- lsu_err_wb  out  1  error flag, qualified by lsu_valid_wb

Behaviour:
- **Reset values:** all outputs 0 except lsu_ready_ex = 1; state = IDLE. Reset mid-operation abandons it. Any later data_rvalid arriving while in IDLE is ignored.
- **FSM states:** IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- **IDLE, on accept:**
  - Register op, size, sext, addr and wdata.
  - Compute offset = addr[1:0] and mask = 0001/0011/1111 by size.
  - split = SPLIT_MISALIGNED & (mask << offset) overflows bit 3.
  - size = 11, or misaligned with SPLIT_MISALIGNED = 0: go to RESP with err = 1 and no bus traffic.
  - Otherwise go to REQ1.
- **REQ1:**
  - Drive data_req = 1, data_addr = {addr[31:2], 00}, data_be = (mask << offset)[3:0], data_wdata = wdata << 8*offset.
  - Hold all of these stable until data_gnt.
  - On data_gnt, go to WAIT1.
- **WAIT1:**
  - data_req = 0.
  - On data_rvalid, latch data_rdata into buf1.
  - If data_err, or split = 0: go to RESP.
  - Otherwise go to REQ2.
- **REQ2:**
  - data_addr = first word address + 4 (wraps modulo 2^32).
  - data_be = (mask << offset)[7:4].
  - data_wdata = wdata >> 8*(4 - offset).
  - On data_gnt, go to WAIT2.
- **WAIT2:** on data_rvalid, latch buf2 and OR data_err into err; go to RESP.
- **Load merge:**
  - raw = ({buf2, buf1} >> 8*offset)[31:0].
  - Byte uses raw[7:0]; half uses raw[15:0].
  - Zero- or sign-extend by sext.
  - Stores, and any operation with err = 1, return 0.
- **RESP:** registered outputs lsu_valid_wb = 1, lsu_rdata_wb, lsu_err_wb for exactly one cycle, then IDLE. No back-pressure: writeback samples in that cycle.
- **Latency:**
  - Accept in cycle T gives data_req at T+1.
  - Aligned access with gnt at T+1 and rvalid at T+2 gives lsu_valid_wb at T+3.
  - Each further grant or response wait cycle adds one.
- **Flush:**
  - Flush in the same cycle as lsu_req_ex blocks the accept.
  - Flush in REQ1/REQ2 with data_gnt = 0 deasserts data_req next cycle and returns to IDLE with no result.
  - Flush in REQ1/REQ2 with data_gnt = 1 counts as granted and behaves as flush in WAIT.
  - Flush in WAIT1/WAIT2 sets killed. The outstanding response is consumed, no second beat is issued, lsu_valid_wb is suppressed, and the FSM returns to IDLE.
  - Flush in RESP is ignored here; writeback handles it.
- **Single outstanding:** at most one beat in flight. data_rvalid outside WAIT states is ignored. Response in the same cycle as a grant is not supported; the earliest response is the cycle after the grant.

Test Plan:
- Aligned LW, addr 0x100, bus rdata 0xDEADBEEF, gnt and rvalid immediate -> data_be 1111 / addr 0x100; lsu_valid_wb at T+3 with rdata 0xDEADBEEF, err 0.
- LB sext, addr 0x203, rdata 0x80112233 -> be 1000; rdata_wb 0xFFFFFF80. Same access as LBU -> 0x00000080.
- Misaligned LW, addr 0x302, beat data 0xAABBCCDD then 0x11223344 -> beat 1 addr 0x300 be 1100, beat 2 addr 0x304 be 0011; rdata_wb 0x3344AABB.
- SW 0x12345678 to addr 0x401 -> beat 1 be 1110 wdata 0x34567800; beat 2 addr 0x404 be 0001 wdata 0x00000012; lsu_valid_wb with rdata 0.
- Misaligned load, first beat data_err = 1 -> no second request; lsu_valid_wb with err 1, rdata 0. Separately, with SPLIT_MISALIGNED = 0, LH addr 0x3 -> err pulse at T+1, no data_req.
- Grant withheld 3 cycles, then flush -> addr and be held stable while waiting, data_req drops, no lsu_valid_wb, lsu_ready_ex high. Separately, reset asserted in WAIT1 -> IDLE, a late rvalid is ignored.
